rx_char_framer: RTL and testbench

Parametrised receive-side character framer for the serial communication path. Replaces the fixed 11-bit bit-in-character counter with a combined sample-clock counter, bit counter and shift register. Detects a start bit on an oversampled serial line, samples each bit at mid-period, and checks optional parity and one or two stop bits. Delivers the parallel character with a one-cycle completion pulse and error flags to the downstream character buffer.

---
 rtl/rx_char_framer_if.sv | 43 ++++
 rtl/rx_char_framer.sv | 197 +++++++++++++++++++
 tb/tb_rx_char_framer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rx_char_framer_if.sv
// Character framer bus: serial line and enable in, parallel character and status out.
// The framer side uses the slave modport; the line/controller side uses master.
// Pure signal bundle; no logic and no added latency.
interface rx_char_framer_if #(
  parameter int DATA_BITS = 8
) ();

  localparam int BCW = $clog2(DATA_BITS + 4);

  logic                 enable;
  logic                 rx_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 char_complete;
  logic                 parity_err;
  logic                 framing_err;
  logic                 busy;
  logic [BCW-1:0]       bit_count;

  // Line side: drives the serial input and enable, observes the character.
  modport master (
    output enable,
    output rx_in,
    input  data_out,
    input  char_complete,
    input  parity_err,
    input  framing_err,
    input  busy,
    input  bit_count
  );

  // Framer side.
  modport slave (
    input  enable,
    input  rx_in,
    output data_out,
    output char_complete,
    output parity_err,
    output framing_err,
    output busy,
    output bit_count
  );

endinterface

// File: rtl/rx_char_framer.sv
// Receive character framer: start detect, mid-bit sampling, optional parity, 1/2 stop bits.
// Latency: char_complete high the cycle after the last stop sample (E(OS/2 + N*OS) from start edge).
// No backpressure: the character buffer must accept every char_complete pulse.
module rx_char_framer #(
  parameter int DATA_BITS  = 8,   // 5..9
  parameter int OVERSAMPLE = 16,  // even, 4..64
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1    // 1 or 2
) (
  input logic               clk,
  input logic               reset,
  rx_char_framer_if.slave   bus
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 4);

  // Sample-counter values at which the start bit is re-checked and a bit is sampled.
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

  // bit_count equals the 1-based index of the bit being sampled (start bit = 0),
  // so these values identify the last data bit and the last stop bit.
  localparam logic [BCW-1:0] DATA_DONE = BCW'(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS + PARITY_EN + STOP_BITS);

  localparam bit PAR_EN  = (PARITY_EN != 0);
  localparam bit ODD_PAR = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_nxt;
  logic [CW-1:0]        cnt_q, cnt_nxt;
  logic [BCW-1:0]       bcnt_q, bcnt_nxt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;
  logic                 stop_err_q;

  logic                 bit_tick;
  logic                 smp_data;
  logic                 smp_par;
  logic                 smp_stop;
  logic                 done;

  assign bit_tick = (cnt_q == BIT_LAST);

  // Next-state, counter and sample-strobe decode; enable low overrides everything.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    bcnt_nxt  = bcnt_q;
    smp_data  = 1'b0;
    smp_par   = 1'b0;
    smp_stop  = 1'b0;
    done      = 1'b0;

    if (!bus.enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      bcnt_nxt  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.rx_in) begin
            state_nxt = S_START;
            cnt_nxt   = '0;
          end
        end

        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_nxt = '0;
            if (!bus.rx_in) begin
              state_nxt = S_DATA;
              bcnt_nxt  = BCW'(1);
            end else begin
              // Glitch shorter than half a bit: silently drop it.
              state_nxt = S_IDLE;
            end
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_tick) begin
            cnt_nxt  = '0;
            smp_data = 1'b1;
            bcnt_nxt = bcnt_q + 1'b1;
            if (bcnt_q == DATA_DONE) begin
              state_nxt = PAR_EN ? S_PARITY : S_STOP;
            end
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end

        S_PARITY: begin
          if (bit_tick) begin
            cnt_nxt   = '0;
            smp_par   = 1'b1;
            bcnt_nxt  = bcnt_q + 1'b1;
            state_nxt = S_STOP;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_tick) begin
            cnt_nxt  = '0;
            smp_stop = 1'b1;
            if (bcnt_q == LAST_BIT) begin
              done      = 1'b1;
              bcnt_nxt  = '0;
              state_nxt = S_IDLE;
            end else begin
              bcnt_nxt = bcnt_q + 1'b1;
            end
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end

        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          bcnt_nxt  = '0;
        end
      endcase
    end
  end

  // State, sample counter and bit counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      bcnt_q  <= bcnt_nxt;
    end
  end

  // Capture data/parity/stop samples; the shift register fills from the MSB end
  // so the first data bit ends up in bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      if (smp_data) begin
        shift_q <= {bus.rx_in, shift_q[DATA_BITS-1:1]};
      end
      if (smp_par) begin
        par_bit_q <= bus.rx_in;
      end
      if (state_q == S_IDLE) begin
        stop_err_q <= 1'b0;
      end else if (smp_stop && !bus.rx_in) begin
        stop_err_q <= 1'b1;
      end
    end
  end

  // Deliver the character and flags on the last stop sample; they then hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.data_out      <= '0;
      bus.char_complete <= 1'b0;
      bus.parity_err    <= 1'b0;
      bus.framing_err   <= 1'b0;
    end else begin
      bus.char_complete <= done;
      if (done) begin
        bus.data_out    <= shift_q;
        // XOR over data plus parity bit: even wants 0, odd wants 1.
        bus.parity_err  <= PAR_EN & ((^shift_q) ^ par_bit_q ^ ODD_PAR);
        bus.framing_err <= stop_err_q | ~bus.rx_in;
      end
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.bit_count = bcnt_q;

endmodule

// File: tb/tb_rx_char_framer.sv
module tb_rx_char_framer;

  logic clk = 1'b0;
  logic reset;
  logic rx [3];
  logic en [3];
  int   cyc = 0;

  int tests = 0;
  int fails = 0;

  // Pulse monitor state per instance (0 = 8N1, 1 = 7E1, 2 = 8N2).
  int         pcnt     [3] = '{0, 0, 0};
  int         last_cyc [3] = '{0, 0, 0};
  int         prev_cyc [3] = '{0, 0, 0};
  logic [8:0] last_dat [3] = '{9'd0, 9'd0, 9'd0};
  logic [8:0] prev_dat [3] = '{9'd0, 9'd0, 9'd0};

  rx_char_framer_if #(.DATA_BITS(8)) if_a ();
  rx_char_framer_if #(.DATA_BITS(7)) if_b ();
  rx_char_framer_if #(.DATA_BITS(8)) if_c ();

  assign if_a.rx_in  = rx[0];
  assign if_a.enable = en[0];
  assign if_b.rx_in  = rx[1];
  assign if_b.enable = en[1];
  assign if_c.rx_in  = rx[2];
  assign if_c.enable = en[2];

  rx_char_framer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .reset(reset), .bus(if_a));
  rx_char_framer #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_7e1 (.clk(clk), .reset(reset), .bus(if_b));
  rx_char_framer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_8n2 (.clk(clk), .reset(reset), .bus(if_c));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if_a.char_complete) begin
      pcnt[0] <= pcnt[0] + 1;  prev_cyc[0] <= last_cyc[0]; last_cyc[0] <= cyc;
      prev_dat[0] <= last_dat[0]; last_dat[0] <= {1'b0, if_a.data_out};
    end
    if (if_b.char_complete) begin
      pcnt[1] <= pcnt[1] + 1;  prev_cyc[1] <= last_cyc[1]; last_cyc[1] <= cyc;
      prev_dat[1] <= last_dat[1]; last_dat[1] <= {2'b0, if_b.data_out};
    end
    if (if_c.char_complete) begin
      pcnt[2] <= pcnt[2] + 1;  prev_cyc[2] <= last_cyc[2]; last_cyc[2] <= cyc;
      prev_dat[2] <= last_dat[2]; last_dat[2] <= {1'b0, if_c.data_out};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive bits LSB first, 16 clocks each; call and return on a negedge.
  task automatic send_line(input int idx, input logic [31:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      rx[idx] = bits[i];
      repeat (16) @(negedge clk);
    end
    rx[idx] = 1'b1;
  endtask

  int c0;
  int p0;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx[i] = 1'b1;
      en[i] = 1'b1;
    end
    @(negedge clk);
    check("rst_data_a",  32'(if_a.data_out), 32'h0);
    check("rst_busy_a",  32'(if_a.busy), 32'h0);
    check("rst_cc_a",    32'(if_a.char_complete), 32'h0);
    check("rst_bcnt_a",  32'(if_a.bit_count), 32'h0);
    check("rst_perr_b",  32'(if_b.parity_err), 32'h0);
    check("rst_ferr_c",  32'(if_c.framing_err), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1 0x55: one pulse, 152 edges after E0.
    c0 = cyc; p0 = pcnt[0];
    send_line(0, {22'b0, 1'b1, 8'h55, 1'b0}, 10);
    check("8n1_npulse", 32'(pcnt[0] - p0), 32'd1);
    check("8n1_lat",    32'(last_cyc[0] - (c0 + 1)), 32'd152);
    check("8n1_data",   32'(if_a.data_out), 32'h55);
    check("8n1_perr",   32'(if_a.parity_err), 32'h0);
    check("8n1_ferr",   32'(if_a.framing_err), 32'h0);
    check("8n1_busy",   32'(if_a.busy), 32'h0);

    // 7E1 0x41 (two ones) with parity bit 1 -> error, then 0 -> clean.
    p0 = pcnt[1];
    send_line(1, {22'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
    check("7e1_perr1", 32'(if_b.parity_err), 32'h1);
    check("7e1_data1", 32'(if_b.data_out), 32'h41);
    send_line(1, {22'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
    check("7e1_perr0", 32'(if_b.parity_err), 32'h0);
    check("7e1_data0", 32'(if_b.data_out), 32'h41);
    check("7e1_ferr",  32'(if_b.framing_err), 32'h0);
    check("7e1_npulse", 32'(pcnt[1] - p0), 32'd2);

    // 8N2 0xA3 with second stop low: framing error, data and pulse still delivered.
    c0 = cyc; p0 = pcnt[2];
    send_line(2, {21'b0, 1'b0, 1'b1, 8'hA3, 1'b0}, 11);
    repeat (20) @(negedge clk);
    check("8n2_ferr",   32'(if_c.framing_err), 32'h1);
    check("8n2_data",   32'(if_c.data_out), 32'hA3);
    check("8n2_perr",   32'(if_c.parity_err), 32'h0);
    check("8n2_npulse", 32'(pcnt[2] - p0), 32'd1);
    check("8n2_lat",    32'(last_cyc[2] - (c0 + 1)), 32'd168);

    // 3-cycle glitch: busy until the start check at E8, then idle, no pulse.
    p0 = pcnt[0];
    rx[0] = 1'b0;
    @(negedge clk);
    check("glitch_busy_e0", 32'(if_a.busy), 32'h1);
    repeat (2) @(negedge clk);
    rx[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("glitch_busy_e7", 32'(if_a.busy), 32'h1);
    @(negedge clk);
    check("glitch_busy_e8", 32'(if_a.busy), 32'h0);
    check("glitch_bcnt",    32'(if_a.bit_count), 32'h0);
    repeat (10) @(negedge clk);
    check("glitch_npulse",  32'(pcnt[0] - p0), 32'd0);
    check("glitch_data",    32'(if_a.data_out), 32'h55);

    // Abort during data bit 4, then a clean 0x3C.
    p0 = pcnt[0];
    send_line(0, {22'b0, 1'b1, 8'h5A, 1'b0}, 5);
    repeat (4) @(negedge clk);
    check("abort_bcnt_pre", 32'(if_a.bit_count), 32'd5);
    check("abort_busy_pre", 32'(if_a.busy), 32'h1);
    en[0] = 1'b0;
    @(negedge clk);
    check("abort_bcnt", 32'(if_a.bit_count), 32'd0);
    check("abort_busy", 32'(if_a.busy), 32'h0);
    repeat (3) @(negedge clk);
    en[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_nopulse", 32'(pcnt[0] - p0), 32'd0);
    c0 = cyc;
    send_line(0, {22'b0, 1'b1, 8'h3C, 1'b0}, 10);
    check("abort_npulse2", 32'(pcnt[0] - p0), 32'd1);
    check("abort_data2",   32'(if_a.data_out), 32'h3C);
    check("abort_lat2",    32'(last_cyc[0] - (c0 + 1)), 32'd152);

    // Back-to-back 0xF0 then 0x0F: pulses 160 cycles apart.
    c0 = cyc; p0 = pcnt[0];
    send_line(0, {12'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 8'hF0, 1'b0}, 20);
    check("b2b_npulse", 32'(pcnt[0] - p0), 32'd2);
    check("b2b_lat1",   32'(prev_cyc[0] - (c0 + 1)), 32'd152);
    check("b2b_gap",    32'(last_cyc[0] - prev_cyc[0]), 32'd160);
    check("b2b_dat1",   32'(prev_dat[0]), 32'hF0);
    check("b2b_dat2",   32'(last_dat[0]), 32'h0F);

    // Asynchronous reset mid-frame: outputs clear immediately, no pulse.
    p0 = pcnt[0];
    send_line(0, {22'b0, 1'b1, 8'hAA, 1'b0}, 4);
    rx[0] = 1'b0;
    check("rst_mid_busy_pre", 32'(if_a.busy), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_data",  32'(if_a.data_out), 32'h0);
    check("rst_mid_busy",  32'(if_a.busy), 32'h0);
    check("rst_mid_bcnt",  32'(if_a.bit_count), 32'h0);
    check("rst_mid_ferr_c", 32'(if_c.framing_err), 32'h0);
    check("rst_mid_data_b", 32'(if_b.data_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rx[0] = 1'b1;
    repeat (200) @(negedge clk);
    check("rst_mid_npulse", 32'(pcnt[0] - p0), 32'd0);
    check("rst_mid_data2",  32'(if_a.data_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
